// File: rtl/seq_mul_add_if.sv
// Operand/result handshake bundle for the sequential multiply-accumulate unit.
// The producer/consumer side uses the master modport, the arithmetic unit the slave modport.
interface seq_mul_add_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [WIDTH-1:0]   addend;
    logic               src_valid;
    logic               src_ready;
    logic [2*WIDTH-1:0] product;
    logic               dest_valid;
    logic               dest_ready;

    modport master (
        output multiplicand, multiplier, addend, src_valid, dest_ready,
        input  src_ready, product, dest_valid
    );

    modport slave (
        input  multiplicand, multiplier, addend, src_valid, dest_ready,
        output src_ready, product, dest_valid
    );
endinterface

// File: rtl/seq_mul_add.sv
// Shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One operand set is accepted in IDLE, exactly WIDTH shift/add iterations run in
// BUSY (no early exit), and the result is held in DONE until the consumer takes it.
module seq_mul_add #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    seq_mul_add_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg,   state_next;
    logic [2*WIDTH-1:0] a_reg,       a_next;
    logic [WIDTH-1:0]   b_reg,       b_next;
    logic [2*WIDTH-1:0] acc_reg,     acc_next;
    logic [CW-1:0]      count_reg,   count_next;
    logic [2*WIDTH-1:0] product_reg, product_next;

    // Shifted multiplicand gated by the current multiplier LSB: the term added this iteration.
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_sum;

    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_partial
            assign partial[gi] = a_reg[gi] & b_reg[0];
        end
    endgenerate

    assign acc_sum     = acc_reg + partial;
    assign bus.product = product_reg;

    // Next-state, datapath updates and handshake outputs, decoded from the current state.
    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        acc_next       = acc_reg;
        count_next     = count_reg;
        product_next   = product_reg;
        bus.src_ready  = 1'b0;
        bus.dest_valid = 1'b0;

        case (state_reg)
            IDLE: begin
                bus.src_ready = 1'b1;
                if (bus.src_valid) begin
                    a_next     = {{WIDTH{1'b0}}, bus.multiplicand};
                    b_next     = bus.multiplier;
                    acc_next   = {{WIDTH{1'b0}}, bus.addend};
                    count_next = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                acc_next   = acc_sum;
                a_next     = a_reg << 1;
                b_next     = b_reg >> 1;
                count_next = count_reg + CW'(1);
                if (count_reg == LAST_COUNT) begin
                    // Capture the final sum so product is already valid as DONE is entered.
                    product_next = acc_sum;
                    state_next   = DONE;
                end
            end
            DONE: begin
                bus.dest_valid = 1'b1;
                if (bus.dest_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            product_reg <= product_next;
        end
    end
endmodule
